// File: rtl/traffic_pkg.sv
// Shared codes for the intersection phase controller: phase codes, head encodings
// and service-direction constants.
package traffic_pkg;

    typedef enum logic [3:0] {
        AR      = 4'd0,
        NS_LT   = 4'd1,
        NS_LT_Y = 4'd2,
        NS_G    = 4'd3,
        NS_Y    = 4'd4,
        EW_LT   = 4'd5,
        EW_LT_Y = 4'd6,
        EW_G    = 4'd7,
        EW_Y    = 4'd8
    } state_t;

    // Signal heads are {R,Y,G}
    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    localparam logic [2:0] DONT  = 3'b100;
    localparam logic [2:0] WALK  = 3'b010;
    localparam logic [2:0] FLASH = 3'b110;

    localparam logic DIR_NS = 1'b0;
    localparam logic DIR_EW = 1'b1;

endpackage

// File: rtl/traffic_phase_ctrl_phase_timer.sv
// Loadable down-counter paced by the shared tick strobe; zero marks the last tick
// of the current phase.
module phase_timer #(
    parameter int CNT_W     = 8,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick_en,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= CNT_W'(RESET_VAL);
        else if (load)
            count <= load_val;
        else if (tick_en && (count != '0))
            count <= count - CNT_W'(1);
    end

    assign zero = (count == '0);

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Intersection phase sequencer: timed through/left/yellow/all-red phases with
// demand-skipped lefts, latched pedestrian calls and emergency preemption.
module traffic_phase_ctrl
    import traffic_pkg::*;
#(
    parameter int GREEN_TICKS  = 8,
    parameter int LEFT_TICKS   = 4,
    parameter int YELLOW_TICKS = 3,
    parameter int ALLRED_TICKS = 1,
    parameter int WALK_TICKS   = 4,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick_en,
    input  logic             car_ns_left,
    input  logic             car_ew_left,
    input  logic             ped_ns,
    input  logic             ped_ew,
    input  logic             preempt_ns,
    input  logic             preempt_ew,
    output logic [2:0]       ns_lights,
    output logic [2:0]       ns_left_lights,
    output logic [2:0]       ew_lights,
    output logic [2:0]       ew_left_lights,
    output logic [2:0]       walk_ns,
    output logic [2:0]       walk_ew,
    output logic [3:0]       phase,
    output logic [CNT_W-1:0] countdown
);

    localparam logic [CNT_W-1:0] WALK_THR = CNT_W'(GREEN_TICKS - WALK_TICKS);

    state_t           state_q, state_d;
    logic             dir_q;
    logic             lt_ns_q, lt_ew_q, pd_ns_q, pd_ew_q, srv_ns_q, srv_ew_q;
    logic             hold, load, expire, pre_ns, pre_ew;
    logic             enter_ns_lt, enter_ew_lt, enter_ns_g, enter_ew_g;
    logic [CNT_W-1:0] timer, load_val;
    logic             zero;

    function automatic logic [CNT_W-1:0] dur_m1(input state_t s);
        case (s)
            NS_LT, EW_LT:                 dur_m1 = CNT_W'(LEFT_TICKS - 1);
            NS_G, EW_G:                   dur_m1 = CNT_W'(GREEN_TICKS - 1);
            NS_LT_Y, NS_Y, EW_LT_Y, EW_Y: dur_m1 = CNT_W'(YELLOW_TICKS - 1);
            default:                      dur_m1 = CNT_W'(ALLRED_TICKS - 1);
        endcase
    endfunction

    // Walk shows while fewer than WALK_TICKS ticks of the green have elapsed
    function automatic logic [2:0] walk_head(input logic [CNT_W-1:0] t);
        walk_head = (t >= WALK_THR) ? WALK : FLASH;
    endfunction

    assign expire = tick_en && zero;
    assign pre_ns = preempt_ns;
    assign pre_ew = preempt_ew && !preempt_ns;

    always_comb begin
        state_d = state_q;
        hold    = 1'b0;
        case (state_q)
            AR: if (expire) begin
                if (pre_ns)               state_d = NS_G;
                else if (pre_ew)          state_d = EW_G;
                else if (dir_q == DIR_NS) state_d = lt_ns_q ? NS_LT : NS_G;
                else                      state_d = lt_ew_q ? EW_LT : EW_G;
            end
            NS_LT:   if (expire || pre_ns || pre_ew) state_d = NS_LT_Y;
            NS_LT_Y: if (expire) state_d = NS_G;
            NS_G: begin
                if (pre_ns)                 hold    = 1'b1;
                else if (expire || pre_ew)  state_d = NS_Y;
            end
            NS_Y:    if (expire) state_d = AR;
            EW_LT:   if (expire || pre_ns || pre_ew) state_d = EW_LT_Y;
            EW_LT_Y: if (expire) state_d = EW_G;
            EW_G: begin
                if (pre_ew)                 hold    = 1'b1;
                else if (expire || pre_ns)  state_d = EW_Y;
            end
            EW_Y:    if (expire) state_d = AR;
            default: state_d = AR;
        endcase
    end

    assign load        = hold || (state_d != state_q);
    assign load_val    = dur_m1(state_d);
    assign enter_ns_lt = (state_d == NS_LT) && (state_q != NS_LT);
    assign enter_ew_lt = (state_d == EW_LT) && (state_q != EW_LT);
    assign enter_ns_g  = (state_d == NS_G)  && (state_q != NS_G);
    assign enter_ew_g  = (state_d == EW_G)  && (state_q != EW_G);

    phase_timer #(
        .CNT_W     (CNT_W),
        .RESET_VAL (ALLRED_TICKS - 1)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .tick_en  (tick_en),
        .load     (load),
        .load_val (load_val),
        .count    (timer),
        .zero     (zero)
    );

    // A request arriving on the clearing cycle survives for the next service
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= AR;
            dir_q    <= DIR_NS;
            lt_ns_q  <= 1'b0;
            lt_ew_q  <= 1'b0;
            pd_ns_q  <= 1'b0;
            pd_ew_q  <= 1'b0;
            srv_ns_q <= 1'b0;
            srv_ew_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == NS_Y && state_d == AR) dir_q <= DIR_EW;
            if (state_q == EW_Y && state_d == AR) dir_q <= DIR_NS;
            lt_ns_q <= car_ns_left || (lt_ns_q && !enter_ns_lt);
            lt_ew_q <= car_ew_left || (lt_ew_q && !enter_ew_lt);
            pd_ns_q <= ped_ns || (pd_ns_q && !enter_ns_g);
            pd_ew_q <= ped_ew || (pd_ew_q && !enter_ew_g);
            if (enter_ns_g) srv_ns_q <= pd_ns_q;
            if (enter_ew_g) srv_ew_q <= pd_ew_q;
        end
    end

    always_comb begin
        ns_lights      = RED;
        ns_left_lights = RED;
        ew_lights      = RED;
        ew_left_lights = RED;
        walk_ns        = DONT;
        walk_ew        = DONT;
        case (state_q)
            NS_LT:   ns_left_lights = GRN;
            NS_LT_Y: ns_left_lights = YEL;
            NS_G: begin
                ns_lights = GRN;
                if (srv_ns_q) walk_ns = walk_head(timer);
            end
            NS_Y:    ns_lights = YEL;
            EW_LT:   ew_left_lights = GRN;
            EW_LT_Y: ew_left_lights = YEL;
            EW_G: begin
                ew_lights = GRN;
                if (srv_ew_q) walk_ew = walk_head(timer);
            end
            EW_Y:    ew_lights = YEL;
            default: ;
        endcase
    end

    assign phase     = state_q;
    assign countdown = timer;

endmodule

// File: doc/traffic_phase_ctrl.md
Name: traffic_phase_ctrl

Overview:
- Parametrised successor to the fixed-delay intersection FSM.
- Drives NS/EW through and protected-left signal heads, plus NS/EW pedestrian heads, from a shared tick strobe.
- Adds programmable phase durations, an all-red clearance interval, demand-skipped left phases, latched pedestrian requests with walk/flash timing, and emergency preemption.
- Exports the phase code and a countdown value for the 7-segment display path.

Parameters:
- GREEN_TICKS, 8, through-green duration in ticks (>= WALK_TICKS+1)
- LEFT_TICKS, 4, protected-left green duration in ticks (>= 1)
- YELLOW_TICKS, 3, yellow duration for all yellow states (>= 1)
- ALLRED_TICKS, 1, all-red clearance duration (>= 1)
- WALK_TICKS, 4, steady-walk portion at the start of a through green
- CNT_W, 8, countdown/timer width; must hold max(duration)-1

Ports:
- clk, input, 1, clock
- reset, input, 1, asynchronous, active-high
- tick_en, input, 1, one-cycle timing strobe from the prescaler; all timing counts these
- car_ns_left, input, 1, NS left-lane demand, level
- car_ew_left, input, 1, EW left-lane demand, level
- ped_ns, input, 1, NS crossing button, level
- ped_ew, input, 1, EW crossing button, level
- preempt_ns, input, 1, emergency preempt toward NS through green
- preempt_ew, input, 1, emergency preempt toward EW through green
- ns_lights, output, 3, {R,Y,G}: 100 red, 010 yellow, 001 green
- ns_left_lights, output, 3, same encoding
- ew_lights, output, 3, same encoding
- ew_left_lights, output, 3, same encoding
- walk_ns, output, 3, 100 don't-walk, 010 walk, 110 flashing don't-walk
- walk_ew, output, 3, same encoding
- phase, output, 4, current state code for display
- countdown, output, CNT_W, ticks remaining minus one in current state

Behaviour:
- State codes: AR=0, NS_LT=1, NS_LT_Y=2, NS_G=3, NS_Y=4, EW_LT=5, EW_LT_Y=6, EW_G=7, EW_Y=8.
- Registered: state, timer, dir, lt/ped latches. All outputs are decoded from registered state only (no input-to-output paths).
- Reset: state=AR, timer=ALLRED_TICKS-1, dir=NS, all latches clear. All heads red (100), both walk heads 100, phase=0, countdown=ALLRED_TICKS-1.
- Timer:
  - On entering a state, load timer with that state's duration-1.
  - Each tick_en decrements the timer.
  - When tick_en is high and timer==0, take the transition. Each state therefore lasts exactly its duration in ticks.
  - Without tick_en, nothing changes.
- Normal sequence:
  - AR with dir=NS goes to NS_LT if lt_ns latched, else NS_G.
  - NS_LT -> NS_LT_Y -> NS_G -> NS_Y -> AR, and dir flips to EW on entry to AR.
  - The EW side mirrors this, then flips back to NS.
- Latches:
  - lt_ns/lt_ew set on any cycle the car input is high.
  - lt_ns clears on NS_LT entry; lt_ew clears on EW_LT entry.
  - ped_ns/ped_ew latch the same way and clear on entry to the respective *_G state; that entry marks that green as "served".
  - A set on the same cycle as a clear leaves the latch set.
- Lights:
  - NS_LT: ns_left green, all other heads red.
  - NS_LT_Y: ns_left yellow, all other heads red.
  - NS_G: ns through green, ns_left red.
  - NS_Y: ns through yellow, ns_left red.
  - EW states mirror the NS states.
  - AR: all four heads red.
- Walk:
  - While NS_G is served, walk_ns=010 for the first WALK_TICKS ticks, then 110 for the rest of the green.
  - walk_ns=100 in every other state and in an unserved green.
  - walk_ew mirrors this.
- Preemption:
  - preempt_ns is sampled every clk and is independent of tick_en.
  - In EW_G or EW_LT: next cycle go to EW_Y or EW_LT_Y respectively, with the timer reloaded.
  - In a yellow or AR: complete normally. AR then goes to NS_G, skipping NS_LT; lt_ns stays latched.
  - In NS_LT: go to NS_LT_Y, then NS_G.
  - In NS_G: hold, reloading the timer each cycle while asserted. After release, a full GREEN_TICKS runs.
  - A preempted green does not advance walk timing; walk stays 100 unless the green was served.
  - preempt_ew mirrors all of the above.
  - Both preempts asserted: NS wins.
- Boundary rules:
  - An illegal state code recovers to AR next cycle.
  - Reset mid-state returns immediately to AR with the reset values.

Decomposition:
- Package traffic_pkg holds:
  - state code constants
  - light encodings RED/YEL/GRN
  - walk encodings DONT/WALK/FLASH
  - direction constants
- Sub-module phase_timer: loadable down-counter with tick_en, load value, and zero flag. Shared-width via CNT_W.

Test Plan (GREEN=4, LEFT=2, YELLOW=2, ALLRED=1, WALK=2, tick_en every cycle):
- Reset release, no inputs -> phase 0, 3, 4, 0, 7, 8, 0 with dwell 1, 4, 2, 1, 4, 2, 1 cycles; no left phases; walk heads stay 100.
- car_ns_left pulsed 1 cycle during EW_G -> next NS side runs NS_LT 2 cycles (ns_left_lights=001), NS_LT_Y 2, then NS_G.
- ped_ns pulsed during EW_Y -> in the next NS_G, walk_ns=010 for 2 cycles then 110 for 2; the following NS_G shows 100.
- preempt_ew raised in NS_G with countdown=3 -> next cycle NS_Y (countdown=1), AR, then EW_G. Held while asserted; after release, 4 more cycles then EW_Y.
- preempt_ns and preempt_ew both high from EW_G -> EW_Y, AR, NS_G held; EW_G is never entered.
- tick_en low for 10 cycles mid NS_Y -> state and countdown frozen. reset pulse mid NS_LT -> immediately phase=0, all heads 100.
